// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t TENTH_MAX = 4'd9;
  localparam bcd_t SECU_MAX  = 4'd9;
  localparam bcd_t SECT_MAX  = 4'd5;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_u;
    bcd_t sec_t;
    bcd_t sec_u;
    bcd_t tenth;
  } time_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Link between the stopwatch controller and the external modulo-100 tick divider.
interface stopwatch_ctrl_if;
  logic div_enable;
  logic div_in;
  logic div_rst_n;
  logic div_timeout;

  modport master (output div_enable, output div_in, output div_rst_n, input div_timeout);
  modport slave  (input div_enable, input div_in, input div_rst_n, output div_timeout);
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One modulo-(MAX+1) BCD digit; clr wins over inc, carry_out is combinational.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry_out
);

  bcd_t value_r;

  // Digit register: wraps to zero after MAX
  always_ff @(posedge clk) begin
    if (!rst) begin
      value_r <= 4'd0;
    end else if (clr) begin
      value_r <= 4'd0;
    end else if (inc) begin
      value_r <= (value_r >= MAX) ? 4'd0 : value_r + 4'd1;
    end else begin
      value_r <= value_r;
    end
  end

  assign value     = value_r;
  assign carry_out = inc & (value_r >= MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the tick divider with BCD MM:SS.t accumulation.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX = 99
) (
  input  logic clk,
  input  logic rst,
  input  logic base_tick,
  input  logic start_stop,
  input  logic clear,
  input  logic lap,
  stopwatch_ctrl_if.master div,
  output bcd_t disp_min_t,
  output bcd_t disp_min_u,
  output bcd_t disp_sec_t,
  output bcd_t disp_sec_u,
  output bcd_t disp_tenth,
  output logic running,
  output logic overflow,
  output logic lap_active
);

  localparam bcd_t MIN_T_MAX = bcd_t'(MIN_MAX / 32'd10);
  localparam bcd_t MIN_U_MAX = bcd_t'(MIN_MAX % 32'd10);

  state_t state_r, state_s;
  time_t  live_s, disp_s;
  logic   tick_s, c_tenth_s, c_secu_s, c_sect_s, c_minu_s, c_mint_unused_s;
  logic   at_max_s, wrap_s, min_clr_s;
  logic   overflow_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: clear has priority over start_stop
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else if (start_stop) begin
      case (state_r)
        IDLE:    state_s = RUN;
        RUN:     state_s = PAUSE;
        PAUSE:   state_s = RUN;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign running        = (state_r == RUN);
  assign div.div_enable = running;
  assign div.div_in     = base_tick & running;
  assign div.div_rst_n  = rst & (state_r != IDLE) & ~clear;

  // A timeout still in flight when RUN becomes PAUSE must be counted
  assign tick_s    = div.div_timeout & (state_r != IDLE) & ~clear;
  assign at_max_s  = (live_s.min_t == MIN_T_MAX) && (live_s.min_u == MIN_U_MAX);
  assign wrap_s    = c_sect_s & at_max_s;
  assign min_clr_s = clear | wrap_s;

  bcd_digit #(.MAX(TENTH_MAX)) u_tenth (.clk(clk), .rst(rst), .clr(clear), .inc(tick_s),
                                        .value(live_s.tenth), .carry_out(c_tenth_s));
  bcd_digit #(.MAX(SECU_MAX))  u_sec_u (.clk(clk), .rst(rst), .clr(clear), .inc(c_tenth_s),
                                        .value(live_s.sec_u), .carry_out(c_secu_s));
  bcd_digit #(.MAX(SECT_MAX))  u_sec_t (.clk(clk), .rst(rst), .clr(clear), .inc(c_secu_s),
                                        .value(live_s.sec_t), .carry_out(c_sect_s));
  bcd_digit #(.MAX(4'd9))      u_min_u (.clk(clk), .rst(rst), .clr(min_clr_s), .inc(c_sect_s),
                                        .value(live_s.min_u), .carry_out(c_minu_s));
  bcd_digit #(.MAX(4'd9))      u_min_t (.clk(clk), .rst(rst), .clr(min_clr_s), .inc(c_minu_s),
                                        .value(live_s.min_t), .carry_out(c_mint_unused_s));

  // Sticky wrap flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r <= 1'b0;
    end else if (wrap_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow = overflow_r;

`ifdef STOPWATCH_LAP_EN
  logic  lap_active_r;
  time_t lap_snap_r;

  // Lap freeze: snapshot takes the registered (pre-update) live time
  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_active_r <= 1'b0;
      lap_snap_r   <= time_t'(20'd0);
    end else if (clear) begin
      lap_active_r <= 1'b0;
    end else if (lap && lap_active_r && (state_r != IDLE)) begin
      lap_active_r <= 1'b0;
    end else if (lap && (state_r == RUN)) begin
      lap_active_r <= 1'b1;
      lap_snap_r   <= live_s;
    end else begin
      lap_active_r <= lap_active_r;
    end
  end

  assign lap_active = lap_active_r;
  assign disp_s     = lap_active_r ? lap_snap_r : live_s;
`else
  logic unused_lap_s;

  assign unused_lap_s = lap;
  assign lap_active   = 1'b0;
  assign disp_s       = live_s;
`endif

  assign disp_min_t = disp_s.min_t;
  assign disp_min_u = disp_s.min_u;
  assign disp_sec_t = disp_s.sec_t;
  assign disp_sec_u = disp_s.sec_u;
  assign disp_tenth = disp_s.tenth;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural modulo-100 divider model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk, rst;
  logic base_tick, start_stop, clear, lap;
  logic use_model, forced1;
  logic ss2, clr2, forced2, bt2, lap2;
  int   checks, failures, to_cnt;

  logic [6:0] model_cnt;
  logic       model_to;

  bcd_t min_t1, min_u1, sec_t1, sec_u1, tenth1;
  bcd_t min_t2, min_u2, sec_t2, sec_u2, tenth2;
  logic running1, overflow1, lap_active1;
  logic running2, overflow2, lap_active2;
  logic [19:0] disp1, disp2;

  stopwatch_ctrl_if div1 ();
  stopwatch_ctrl_if div2 ();

  assign div1.div_timeout = use_model ? model_to : forced1;
  assign div2.div_timeout = forced2;
  assign disp1 = {min_t1, min_u1, sec_t1, sec_u1, tenth1};
  assign disp2 = {min_t2, min_u2, sec_t2, sec_u2, tenth2};

  stopwatch_ctrl #(.MIN_MAX(99)) dut (
    .clk(clk), .rst(rst), .base_tick(base_tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .div(div1),
    .disp_min_t(min_t1), .disp_min_u(min_u1), .disp_sec_t(sec_t1),
    .disp_sec_u(sec_u1), .disp_tenth(tenth1),
    .running(running1), .overflow(overflow1), .lap_active(lap_active1)
  );

  stopwatch_ctrl #(.MIN_MAX(1)) dut2 (
    .clk(clk), .rst(rst), .base_tick(bt2), .start_stop(ss2),
    .clear(clr2), .lap(lap2), .div(div2),
    .disp_min_t(min_t2), .disp_min_u(min_u2), .disp_sec_t(sec_t2),
    .disp_sec_u(sec_u2), .disp_tenth(tenth2),
    .running(running2), .overflow(overflow2), .lap_active(lap_active2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: timeout registered one cycle after the 100th counted in
  always_ff @(posedge clk) begin
    if (!div1.div_rst_n) begin
      model_cnt <= 7'd0;
      model_to  <= 1'b0;
    end else if (div1.div_enable && div1.div_in) begin
      model_to  <= (model_cnt == 7'd99);
      model_cnt <= (model_cnt == 7'd99) ? 7'd0 : model_cnt + 7'd1;
    end else begin
      model_to  <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; to_cnt = 0;
    rst = 1'b0; base_tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    use_model = 1'b1; forced1 = 1'b0;
    ss2 = 1'b0; clr2 = 1'b0; forced2 = 1'b0; bt2 = 1'b0; lap2 = 1'b0;
    repeat (3) step();
    check("rst_running", running1, 1'b0);
    check("rst_disp", disp1, 20'h00000);
    check("rst_overflow", overflow1, 1'b0);
    check("rst_lap_active", lap_active1, 1'b0);
    check("rst_div_rst_n", div1.div_rst_n, 1'b0);
    rst = 1'b1;
    step();
    check("idle_running", running1, 1'b0);

    // Latency from start with base_tick held high
    base_tick = 1'b1;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("start_running", running1, 1'b1);
    check("start_div_in", div1.div_in, 1'b1);
    check("start_div_rst_n", div1.div_rst_n, 1'b1);
    repeat (99) step();
    check("t100_timeout", div1.div_timeout, 1'b0);
    step();
    check("t101_timeout", div1.div_timeout, 1'b1);
    check("t101_disp", disp1, 20'h00000);
    step();
    check("t102_disp", disp1, 20'h00001);

    // Fast-forward 599 more tenths to one minute
    base_tick = 1'b0; use_model = 1'b0; forced1 = 1'b1;
    repeat (599) step();
    forced1 = 1'b0;
    check("one_minute", disp1, 20'h01000);
    check("one_minute_ovf", overflow1, 1'b0);

    // Pause mid-tenth preserves divider phase
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_disp", disp1, 20'h00000);
    use_model = 1'b1; base_tick = 1'b1;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (149) step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("pause_running", running1, 1'b0);
    check("pause_disp", disp1, 20'h00001);
    to_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (div1.div_timeout === 1'b1) to_cnt++;
    end
    check("pause_no_timeout", to_cnt, 0);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("resume_running", running1, 1'b1);
    repeat (49) step();
    check("resume_49_timeout", div1.div_timeout, 1'b0);
    step();
    check("resume_50_timeout", div1.div_timeout, 1'b1);
    step();
    check("resume_disp", disp1, 20'h00002);

    // start_stop and clear together in RUN
    start_stop = 1'b1; clear = 1'b1;
    #1;
    check("clr_ss_div_rst_n", div1.div_rst_n, 1'b0);
    step();
    start_stop = 1'b0; clear = 1'b0;
    check("clr_ss_running", running1, 1'b0);
    check("clr_ss_disp", disp1, 20'h00000);
    check("clr_ss_div_in", div1.div_in, 1'b0);

    // Timeout coincident with stop pulse is counted
    base_tick = 1'b0; use_model = 1'b0;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    start_stop = 1'b1; forced1 = 1'b1;
    step();
    start_stop = 1'b0; forced1 = 1'b0;
    check("coinc_running", running1, 1'b0);
    check("coinc_disp", disp1, 20'h00001);
    forced1 = 1'b1;
    step();
    forced1 = 1'b0;
    check("pause_tick_disp", disp1, 20'h00002);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // Lap freeze, with lap coincident with a timeout at 00:03.2
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    forced1 = 1'b1;
    repeat (32) step();
    forced1 = 1'b0;
    check("lap_pre_disp", disp1, 20'h00032);
    lap = 1'b1; forced1 = 1'b1;
    step();
    lap = 1'b0; forced1 = 1'b0;
`ifdef STOPWATCH_LAP_EN
    check("lap_active_set", lap_active1, 1'b1);
    check("lap_frozen", disp1, 20'h00032);
    forced1 = 1'b1;
    repeat (17) step();
    forced1 = 1'b0;
    check("lap_still_frozen", disp1, 20'h00032);
    lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap_release_active", lap_active1, 1'b0);
    check("lap_release_disp", disp1, 20'h00050);
`else
    check("nolap_active", lap_active1, 1'b0);
    check("nolap_live", disp1, 20'h00033);
    forced1 = 1'b1;
    repeat (17) step();
    forced1 = 1'b0;
    check("nolap_live_5s", disp1, 20'h00050);
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("lap_clear_active", lap_active1, 1'b0);

    // MIN_MAX=1 wrap and sticky overflow
    ss2 = 1'b1;
    step();
    ss2 = 1'b0;
    forced2 = 1'b1;
    repeat (1199) step();
    forced2 = 1'b0;
    check("mm1_top", disp2, 20'h01599);
    check("mm1_top_ovf", overflow2, 1'b0);
    forced2 = 1'b1;
    step();
    forced2 = 1'b0;
    check("mm1_wrap_disp", disp2, 20'h00000);
    check("mm1_wrap_ovf", overflow2, 1'b1);
    forced2 = 1'b1;
    step();
    forced2 = 1'b0;
    check("mm1_after_disp", disp2, 20'h00001);
    check("mm1_sticky_ovf", overflow2, 1'b1);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    check("mm1_clear_ovf", overflow2, 1'b0);
    check("mm1_clear_running", running2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
